mips_instruction_synthesize: RTL
================================

// Module: mips_instruction_synthesize
// PURPOSE
//   Inverse of the op/func categorizer: given a requested instruction category and a count, emits that
//   many pseudo-random 32-bit MIPS instruction words whose op/func fields fall in that category.
//   Drives the instruction-memory/fetch test path and lets the bench check categorization end to end.
//   LFSR-driven generator with valid/ready handshakes on both the request and instruction sides.
// PARAMETERS
//   SEED        32'hACE1_2468  LFSR reset value; 0 is replaced by 32'h1 to avoid lock-up
//   COUNT_W     16             width of the request count
// PORTS
//   clock        input   1        rising-edge clock
//   reset        input   1        asynchronous, active-low reset
//   reqValid     input   1        request present
//   reqReady     output  1        request accepted when reqValid && reqReady
//   reqCategory  input   4        Mips_Instruction_Category_*_V code, per Category.v
//   reqCount     input   COUNT_W  number of words to emit
//   instValid    output  1        instruction word present
//   instReady    input   1        consumer takes the word when instValid && instReady
//   instruction  output  32       generated word
//   instLast     output  1        high with the final word of a request
//   busy         output  1        FSM not in IDLE
// BEHAVIOUR
//   Reset (async, reset==0): FSM=IDLE, reqReady=1, instValid=0, instLast=0, busy=0, instruction=0,
//     lfsr=SEED (or 1 if SEED==0), remaining=0. Reset mid-request abandons it; no partial word survives.
//   FSM IDLE: reqReady=1. On a request handshake, latch category and remaining=reqCount.
//     reqCount==0 -> stay in IDLE; nothing emitted.
//     Otherwise -> EMIT; the first word is valid in the next cycle (1-cycle latency).
//   FSM EMIT: reqReady=0, busy=1, instValid=1. The word, instLast and the LFSR are frozen
//     while instValid && !instReady.
//     On an inst handshake: remaining-=1, LFSR steps once. If the word was the last one ->
//     IDLE next cycle (instValid=0, reqReady=1). Otherwise the next word is valid the next cycle with no bubble.
//     instLast = (remaining==1).
//   LFSR: 32-bit Galois, taps 0x8020_0003, stepping exactly once per consumed word.
//     The word is built combinationally from the current LFSR state r and registered:
//     rs=r[25:21], rt=r[20:16], rd=r[15:11], shamt=r[10:6], imm/target from r.
//   Field rules (op=[31:26], func=[5:0]). R-type categories set op=0:
//     RShift  func=0000,r[1:0] if r[31]==0 else 001,r[2:0]
//     RShiftV func=0001,r[1:0]
//     RHilo   func=010,r[2:0]
//     RLong   func=011,r[2:0]
//     RArith  func=1000,r[1:0]
//     RLogic  func=1001,r[1:0]
//     RComp   func=101,r[2:0]
//   I/J-type categories (op as listed):
//     Branch  op=000001 if r[31]==0 else 0001,r[27:26]
//     Jump    op=00001,r[26]
//     Arith   op=00100,r[26]
//     Comp    op=00101,r[26]
//     Logic   op=0011,r[27:26]
//     Load    op=100,r[28:26]
//     Store   op=101,r[28:26]
//   Other op=01,r[29:26]. Any unlisted/undefined category code is treated as Other.
//   Invariant: every emitted word re-categorizes to the latched category (Other for undefined codes).
//   reqCategory/reqCount are sampled only at the handshake; later changes have no effect.
// TESTING
//   1 Reset with SEED=0 -> lfsr=1; outputs as listed; reqReady=1 during and after reset.
//   2 req {Load,3}, instReady=1 -> instValid on cycles t+1..t+3, op[31:29]=3'b100, instLast only on 3rd;
//     reqReady=1 at t+4.
//   3 req {RArith,4}, instReady toggling 1010 -> each word holds stable while stalled; exactly 4 words,
//     op=0, func[5:2]=4'b1000.
//   4 req {x,0} -> no instValid; busy stays 0; a new request is accepted the next cycle.
//   5 Sweep all 16 codes x 256 words each; feed every word to the categorizer -> matches the latched
//     category (Other for undefined codes); the same SEED reproduces an identical word stream.
//   6 Assert reset low mid-EMIT with 5 words remaining -> instValid=0 immediately; after release the
//     word stream restarts from SEED.

Source files
------------

// File: rtl/mips_instruction_synthesize.sv
// Pseudo-random MIPS instruction generator: emits reqCount words whose op/func
// fields fall in the requested category, driven by a 32-bit Galois LFSR.
module mips_instruction_synthesize #(
   parameter logic [31:0]  SEED    = 32'hACE1_2468,
   parameter int unsigned  COUNT_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               reqValid,
   output logic               reqReady,
   input  logic [3:0]         reqCategory,
   input  logic [COUNT_W-1:0] reqCount,
   output logic               instValid,
   input  logic               instReady,
   output logic [31:0]        instruction,
   output logic               instLast,
   output logic               busy
);

   localparam logic [31:0] TAPS     = 32'h8020_0003;
   localparam logic [31:0] SEED_EFF = (SEED == '0) ? 32'h1 : SEED;

   typedef enum logic [3:0] {
      CAT_RSHIFT  = 4'd0,
      CAT_RSHIFTV = 4'd1,
      CAT_RHILO   = 4'd2,
      CAT_RLONG   = 4'd3,
      CAT_RARITH  = 4'd4,
      CAT_RLOGIC  = 4'd5,
      CAT_RCOMP   = 4'd6,
      CAT_BRANCH  = 4'd7,
      CAT_JUMP    = 4'd8,
      CAT_ARITH   = 4'd9,
      CAT_COMP    = 4'd10,
      CAT_LOGIC   = 4'd11,
      CAT_LOAD    = 4'd12,
      CAT_STORE   = 4'd13,
      CAT_OTHER   = 4'd14
   } cat_e;

   typedef enum logic {
      IDLE,
      EMIT
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        lfsr_q, lfsr_d;
   logic [COUNT_W-1:0] remaining_q;
   logic [3:0]         cat_q, cat_sel;
   logic               req_hs, inst_hs, load_word;
   logic               rtype;
   logic [5:0]         op, func;
   logic [31:0]        word_d;

   function automatic logic [31:0] lfsr_step(input logic [31:0] r);
      lfsr_step = {1'b0, r[31:1]} ^ (r[0] ? TAPS : '0);
   endfunction

   // FSM next-state and handshake decode
   always_comb begin
      state_d   = state_q;
      reqReady  = 1'b0;
      instValid = 1'b0;
      busy      = 1'b0;
      instLast  = 1'b0;
      req_hs    = 1'b0;
      inst_hs   = 1'b0;
      load_word = 1'b0;
      case (state_q)
         IDLE: begin
            reqReady = 1'b1;
            if (reqValid) begin
               req_hs = 1'b1;
               if (reqCount != '0) begin
                  state_d   = EMIT;
                  load_word = 1'b1;
               end
            end
         end
         EMIT: begin
            instValid = 1'b1;
            busy      = 1'b1;
            instLast  = (remaining_q == COUNT_W'(1));
            if (instReady) begin
               inst_hs = 1'b1;
               if (remaining_q == COUNT_W'(1)) begin
                  state_d = IDLE;
               end else begin
                  load_word = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The next word is built from the post-step LFSR so it is ready with no bubble.
   always_comb begin
      lfsr_d  = inst_hs ? lfsr_step(lfsr_q) : lfsr_q;
      cat_sel = req_hs ? reqCategory : cat_q;
   end

   always_comb begin
      rtype = 1'b0;
      op    = '0;
      func  = '0;
      case (cat_sel)
         CAT_RSHIFT: begin
            rtype = 1'b1;
            func  = lfsr_d[31] ? {3'b001, lfsr_d[2:0]} : {4'b0000, lfsr_d[1:0]};
         end
         CAT_RSHIFTV: begin
            rtype = 1'b1;
            func  = {4'b0001, lfsr_d[1:0]};
         end
         CAT_RHILO: begin
            rtype = 1'b1;
            func  = {3'b010, lfsr_d[2:0]};
         end
         CAT_RLONG: begin
            rtype = 1'b1;
            func  = {3'b011, lfsr_d[2:0]};
         end
         CAT_RARITH: begin
            rtype = 1'b1;
            func  = {4'b1000, lfsr_d[1:0]};
         end
         CAT_RLOGIC: begin
            rtype = 1'b1;
            func  = {4'b1001, lfsr_d[1:0]};
         end
         CAT_RCOMP: begin
            rtype = 1'b1;
            func  = {3'b101, lfsr_d[2:0]};
         end
         CAT_BRANCH: op = lfsr_d[31] ? {4'b0001, lfsr_d[27:26]} : 6'b000001;
         CAT_JUMP:   op = {5'b00001, lfsr_d[26]};
         CAT_ARITH:  op = {5'b00100, lfsr_d[26]};
         CAT_COMP:   op = {5'b00101, lfsr_d[26]};
         CAT_LOGIC:  op = {4'b0011, lfsr_d[27:26]};
         CAT_LOAD:   op = {3'b100, lfsr_d[28:26]};
         CAT_STORE:  op = {3'b101, lfsr_d[28:26]};
         default:    op = {2'b01, lfsr_d[29:26]};
      endcase
      word_d = rtype ? {6'b000000, lfsr_d[25:6], func} : {op, lfsr_d[25:0]};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lfsr_q      <= SEED_EFF;
         remaining_q <= '0;
         cat_q       <= '0;
         instruction <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         if (req_hs) begin
            cat_q       <= reqCategory;
            remaining_q <= reqCount;
         end else if (inst_hs) begin
            remaining_q <= remaining_q - COUNT_W'(1);
         end
         if (load_word) begin
            instruction <= word_d;
         end
      end
   end

endmodule
